// File: rtl/maze_mem_pkg.sv
// ============================================================================
//  Package  : maze_mem_pkg
//  Purpose  : Shared types and constants for the maze memory bus master.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package maze_mem_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        FINISH  = 3'd4
    } state_t;

    localparam logic       MODE_FILL  = 1'b0;
    localparam logic       MODE_READ  = 1'b1;
    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] BE_ALL     = 4'hF;

endpackage : maze_mem_pkg

`default_nettype wire

// File: rtl/maze_accelerometer_mem_master.sv
// ============================================================================
//  Module   : maze_accelerometer_mem_master
//  Purpose  : Avalon-MM master that fills a word range with seed+i or reads it
//             back accumulating a checksum. Optional read-back comparator is
//             enabled by defining MEM_MASTER_VERIFY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module maze_accelerometer_mem_master
    import maze_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic [31:0]       checksum,
    output logic [LEN_W-1:0]  err_count,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_idx;
    logic [31:0]       r_seed;
    logic [31:0]       r_checksum;

    logic              w_idle_start;
    logic [LEN_W-1:0]  w_idx_inc;
    logic              w_last;
    logic              w_wr_accept;
    logic              w_rd_accept;
    logic              w_rd_take;
    logic [31:0]       w_pattern;
    logic [ADDR_W-1:0] w_addr;

    assign w_idle_start = (r_state == IDLE) && start;
    assign w_idx_inc    = r_idx + LEN_W'(1);
    assign w_last       = (w_idx_inc == r_len);
    assign w_wr_accept  = (r_state == WR_REQ) && !avm_waitrequest;
    assign w_rd_accept  = (r_state == RD_REQ) && !avm_waitrequest;
    // A zero-latency slave may return data in the same cycle the read is accepted.
    assign w_rd_take    = (w_rd_accept || (r_state == RD_WAIT)) && avm_readdatavalid;
    assign w_pattern    = r_seed + 32'(r_idx);
    assign w_addr       = r_base + ADDR_W'(r_idx) * ADDR_W'(WORD_BYTES);

    assign checksum       = r_checksum;
    assign avm_byteenable = BE_ALL;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (length == '0)
                        w_next_state = FINISH;
                    else if (mode == MODE_READ)
                        w_next_state = RD_REQ;
                    else
                        w_next_state = WR_REQ;
                end
            end
            WR_REQ: begin
                if (!avm_waitrequest && w_last)
                    w_next_state = FINISH;
            end
            RD_REQ: begin
                if (!avm_waitrequest) begin
                    if (avm_readdatavalid)
                        w_next_state = w_last ? FINISH : RD_REQ;
                    else
                        w_next_state = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (avm_readdatavalid)
                    w_next_state = w_last ? FINISH : RD_REQ;
            end
            FINISH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_address   = '0;
        avm_writedata = '0;
        case (r_state)
            WR_REQ: begin
                busy          = 1'b1;
                avm_write     = 1'b1;
                avm_address   = w_addr;
                avm_writedata = w_pattern;
            end
            RD_REQ: begin
                busy        = 1'b1;
                avm_read    = 1'b1;
                avm_address = w_addr;
            end
            RD_WAIT: busy = 1'b1;
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base     <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_seed     <= '0;
            r_checksum <= '0;
        end else if (w_idle_start) begin
            r_base     <= base_addr & ~ADDR_W'(WORD_BYTES - 1);
            r_len      <= length;
            r_idx      <= '0;
            r_seed     <= seed;
            r_checksum <= '0;
        end else begin
            if (w_wr_accept || w_rd_take)
                r_idx <= w_idx_inc;
            if (w_rd_take)
                r_checksum <= r_checksum + avm_readdata;
        end
    end

`ifdef MEM_MASTER_VERIFY_EN
    logic [LEN_W-1:0] r_err_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_idle_start) begin
            r_err_count <= '0;
        end else if (w_rd_take && (avm_readdata != w_pattern) && (r_err_count != '1)) begin
            r_err_count <= r_err_count + LEN_W'(1);
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

endmodule : maze_accelerometer_mem_master

`default_nettype wire

// File: tb/tb_maze_accelerometer_mem_master.sv
// ============================================================================
//  Module   : tb_maze_accelerometer_mem_master
//  Purpose  : Scoreboard bench for the memory master against a memory model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maze_accelerometer_mem_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [15:0] base_addr;
    logic [14:0] length;
    logic [31:0] seed;
    logic        busy;
    logic        done;
    logic [31:0] checksum;
    logic [14:0] err_count;
    logic [15:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

`ifdef MEM_MASTER_VERIFY_EN
    localparam logic [14:0] c_exp_err = 15'd1;
`else
    localparam logic [14:0] c_exp_err = 15'd0;
`endif

    always #5 clk = ~clk;

    maze_accelerometer_mem_master #(.ADDR_W(16), .LEN_W(15)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .base_addr(base_addr), .length(length), .seed(seed),
        .busy(busy), .done(done), .checksum(checksum), .err_count(err_count),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid)
    );

    // Memory slave model: programmable stall on the N-th accepted request, latency 0 or 1.
    logic [31:0] mem [0:16383];
    logic        lat0;
    int unsigned acc_cnt   = 0;
    int unsigned stall_cnt = 0;
    int unsigned stall_at;
    int unsigned stall_len;
    logic        pend      = 1'b0;
    logic [31:0] pend_data;
    logic        corrupt_en;
    logic [15:0] corrupt_addr;
    logic        req;
    logic [31:0] mem_rd;

    assign req               = avm_read | avm_write;
    assign avm_waitrequest   = req && (acc_cnt == stall_at) && (stall_cnt < stall_len);
    assign mem_rd            = mem[avm_address[15:2]] ^
                               ((corrupt_en && avm_address == corrupt_addr) ? 32'h1 : 32'h0);
    assign avm_readdatavalid = lat0 ? (avm_read && !avm_waitrequest) : pend;
    assign avm_readdata      = lat0 ? mem_rd : pend_data;

    always @(posedge clk) begin
        pend <= 1'b0;
        if (req) begin
            if (avm_waitrequest) begin
                stall_cnt <= stall_cnt + 1;
            end else begin
                acc_cnt   <= acc_cnt + 1;
                stall_cnt <= 0;
            end
        end
        if (avm_read && !avm_waitrequest && !lat0) begin
            pend      <= 1'b1;
            pend_data <= mem_rd;
        end
        if (avm_write && !avm_waitrequest)
            mem[avm_address[15:2]] <= avm_writedata;
    end

    typedef enum {K_WR, K_RD, K_DONE} kind_e;
    typedef struct {
        kind_e       kind;
        logic [15:0] addr;
        logic [31:0] data;
        logic [14:0] err;
    } exp_t;
    typedef struct {
        logic        busy;
        logic        done;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        bit          chk_addr;
        bit          full;
        bit          is_end;
    } probe_t;

    exp_t   exp_q[$];
    probe_t probe_q[$];
    int     probe_seq  = 0;
    int     probe_seen = 0;
    int     n_total    = 0;
    int     n_pass     = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_addr;
    logic [31:0] prev_data;

    task automatic check_txn(input kind_e k, input logic [15:0] a, input logic [31:0] d,
                             input logic [14:0] e);
        exp_t x;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_%s: addr=%h data=%h err=%0d, required no transaction",
                     k.name(), a, d, e);
            return;
        end
        x = exp_q.pop_front();
        if (x.kind == k && x.addr == a && x.data == d && x.err == e)
            n_pass++;
        else
            $display("FAIL txn_%s: got addr=%h data=%h err=%0d, required %s addr=%h data=%h err=%0d",
                     k.name(), a, d, e, x.kind.name(), x.addr, x.data, x.err);
    endtask

    // Monitor: the single process that compares and counts.
    initial begin
        probe_t p;
        logic   ok;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (prev_stall && avm_write) begin
                    n_total++;
                    if (avm_address == prev_addr && avm_writedata == prev_data)
                        n_pass++;
                    else
                        $display("FAIL stall_hold: addr=%h data=%h, required addr=%h data=%h",
                                 avm_address, avm_writedata, prev_addr, prev_data);
                end
                prev_stall = avm_write && avm_waitrequest;
                prev_addr  = avm_address;
                prev_data  = avm_writedata;
                if (avm_write && !avm_waitrequest)
                    check_txn(K_WR, avm_address, avm_writedata, 15'd0);
                if (avm_read && !avm_waitrequest)
                    check_txn(K_RD, avm_address, 32'd0, 15'd0);
                if (done)
                    check_txn(K_DONE, 16'd0, checksum, err_count);
            end
            if (probe_seq != probe_seen) begin
                probe_seen = probe_seq;
                p = probe_q.pop_front();
                n_total++;
                if (p.is_end) begin
                    if (exp_q.size() == 0)
                        n_pass++;
                    else
                        $display("FAIL leftover: %0d expected transactions never seen, required 0",
                                 exp_q.size());
                end else begin
                    ok = (busy == p.busy) && (done == p.done) && (avm_read == p.rd) &&
                         (avm_write == p.wr) && (!p.chk_addr || avm_address == p.addr);
                    if (p.full)
                        ok = ok && (avm_writedata == 32'd0) && (checksum == 32'd0) &&
                             (err_count == 15'd0) && (avm_byteenable == 4'hF);
                    if (ok)
                        n_pass++;
                    else
                        $display("FAIL probe: busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h sum=%h err=%0d be=%h, required busy=%b done=%b rd=%b wr=%b addr=%h%s",
                                 busy, done, avm_read, avm_write, avm_address, avm_writedata,
                                 checksum, err_count, avm_byteenable,
                                 p.busy, p.done, p.rd, p.wr, p.addr,
                                 p.full ? " wdata/sum/err=0 be=f" : "");
                end
            end
        end
    end

    task automatic probe(input logic b, input logic d, input logic r, input logic w,
                         input logic [15:0] a, input bit ca, input bit full);
        probe_q.push_back('{b, d, r, w, a, ca, full, 1'b0});
        probe_seq++;
        @(negedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [31:0] d);
        exp_q.push_back('{K_WR, a, d, 15'd0});
    endtask

    task automatic push_rd(input logic [15:0] a);
        exp_q.push_back('{K_RD, a, 32'd0, 15'd0});
    endtask

    task automatic push_done(input logic [31:0] sum, input logic [14:0] e);
        exp_q.push_back('{K_DONE, 16'd0, sum, e});
    endtask

    task automatic start_op(input logic m, input logic [15:0] b, input logic [14:0] len,
                            input logic [31:0] sd);
        @(posedge clk);
        #1;
        mode      = m;
        base_addr = b;
        length    = len;
        seed      = sd;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) break;
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        mode         = 1'b0;
        base_addr    = 16'd0;
        length       = 15'd0;
        seed         = 32'd0;
        lat0         = 1'b0;
        stall_at     = 32'hFFFF_FFFF;
        stall_len    = 0;
        corrupt_en   = 1'b0;
        corrupt_addr = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        probe(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        reset = 1'b0;
        probe(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Fill without stalls; a start held through the last write and done is ignored.
        for (int k = 0; k < 4; k++) push_wr(16'h0100 + 16'(4 * k), 32'hA0 + 32'(k));
        push_done(32'd0, 15'd0);
        start_op(1'b0, 16'h0100, 15'd4, 32'hA0);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                mode  = 1'b1;
                start = 1'b1;
            end
            probe(1'b1, 1'b0, 1'b0, 1'b1, 16'h0100 + 16'(4 * k), 1'b1, 1'b0);
        end
        probe(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        start = 1'b0;
        probe(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

        // Read back with a 1-cycle and then a 0-cycle latency slave.
        for (int pass = 0; pass < 2; pass++) begin
            lat0 = (pass == 1);
            for (int k = 0; k < 4; k++) push_rd(16'h0100 + 16'(4 * k));
            push_done(32'h286, 15'd0);
            start_op(1'b1, 16'h0100, 15'd4, 32'hA0);
            wait_done(40);
        end
        lat0 = 1'b0;

        // Zero length: no bus traffic, checksum cleared.
        push_done(32'd0, 15'd0);
        start_op(1'b0, 16'h0300, 15'd0, 32'h55);
        probe(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        probe(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

        // Three-cycle stall on the second write.
        stall_at  = acc_cnt + 1;
        stall_len = 3;
        for (int k = 0; k < 4; k++) push_wr(16'h0200 + 16'(4 * k), 32'h1122_3344 + 32'(k));
        push_done(32'd0, 15'd0);
        start_op(1'b0, 16'h0200, 15'd4, 32'h1122_3344);
        wait_done(40);
        stall_len = 0;

        // Address wrap at the top of the span, then read back with low base bits set.
        push_wr(16'hFFFC, 32'd5);
        push_wr(16'h0000, 32'd6);
        push_done(32'd0, 15'd0);
        start_op(1'b0, 16'hFFFC, 15'd2, 32'd5);
        wait_done(20);
        push_rd(16'hFFFC);
        push_rd(16'h0000);
        push_done(32'd11, 15'd0);
        start_op(1'b1, 16'hFFFE, 15'd2, 32'd5);
        wait_done(20);

        // Corrupted word 2: checksum 0xA0+0xA1+0xA3+0xA3, one mismatch when verifying.
        corrupt_en   = 1'b1;
        corrupt_addr = 16'h0108;
        for (int k = 0; k < 4; k++) push_rd(16'h0100 + 16'(4 * k));
        push_done(32'h287, c_exp_err);
        start_op(1'b1, 16'h0100, 15'd4, 32'hA0);
        wait_done(40);
        corrupt_en = 1'b0;

        // Reset while a read is stalled: outputs drop before the next clock, no done.
        stall_at  = acc_cnt;
        stall_len = 1000;
        start_op(1'b1, 16'h0100, 15'd4, 32'hA0);
        probe(1'b1, 1'b0, 1'b1, 1'b0, 16'h0100, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        probe(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        stall_len = 0;
        repeat (6) @(posedge clk);
        #1;

        probe_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
        probe_seq++;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_maze_accelerometer_mem_master

`default_nettype wire
